// File: rtl/cnt_ld_ctrl.sv
// Sequencing controller for a loadable up-counter: turns it into a one-shot or
// auto-reload interval timer with a terminal-count tick and a period counter.
module cnt_ld_ctrl #(
    parameter int unsigned n        = 4,
    parameter int unsigned PERIOD_W = 8
) (
    input  logic                Clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic                mode,
    input  logic [n-1:0]        start_val,
    input  logic [n-1:0]        end_val,
    input  logic [n-1:0]        q_in,
    output logic                en_o,
    output logic                ld_o,
    output logic [n-1:0]        d_o,
    output logic                busy,
    output logic                tick,
    output logic                done,
    output logic [PERIOD_W-1:0] periods
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [n-1:0]        sv_q, sv_d;
    logic [n-1:0]        ev_q, ev_d;
    logic                mode_q, mode_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic                match;

    assign match   = (q_in == ev_q);
    assign busy    = (state_q != S_IDLE);
    assign d_o     = sv_q;
    assign periods = per_q;

    // State and latched configuration registers
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            sv_q    <= '0;
            ev_q    <= '0;
            mode_q  <= 1'b0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            sv_q    <= sv_d;
            ev_q    <= ev_d;
            mode_q  <= mode_d;
            per_q   <= per_d;
        end
    end

    // Next-state and counter control; stop overrides every control output
    always_comb begin
        state_d = state_q;
        sv_d    = sv_q;
        ev_d    = ev_q;
        mode_d  = mode_q;
        per_d   = per_q;
        en_o    = 1'b0;
        ld_o    = 1'b0;
        tick    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    sv_d    = start_val;
                    ev_d    = end_val;
                    mode_d  = mode;
                    per_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    ld_o    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (match) begin
                    tick    = 1'b1;
                    done    = !mode_q;
                    per_d   = PERIOD_W'(per_q + 1'b1);
                    state_d = mode_q ? S_LOAD : S_IDLE;
                end else begin
                    en_o = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/cnt_ld_ctrl.md
Name: cnt_ld_ctrl

Overview:
- Sequencing controller that sits directly upstream of the loadable up-counter (Cnt_Ld) and drives its en, ld and D inputs.
- Monitors the counter output q and turns the free counter into a programmable interval timer with one-shot and auto-reload modes.
- Emits a one-cycle tick at each terminal count and keeps a count of completed periods.

Parameters:
- n, 4, counter width; must match the n of the attached Cnt_Ld.
- PERIOD_W, 8, width of the completed-period counter.

Ports:
- Clk  input  1  system clock; rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  start request; sampled only in IDLE.
- stop  input  1  abort request; takes priority over everything except reset.
- mode  input  1  0 = one-shot, 1 = auto-reload; latched when start is accepted.
- start_val  input  n  load value; latched when start is accepted.
- end_val  input  n  terminal value; latched when start is accepted.
- q_in  input  n  counter output q, fed back from Cnt_Ld.
- en_o  output  1  counter enable; drives Cnt_Ld en.
- ld_o  output  1  counter load; drives Cnt_Ld ld.
- d_o  output  n  counter load data; drives Cnt_Ld D.
- busy  output  1  high in any state other than IDLE.
- tick  output  1  one-cycle pulse at terminal count.
- done  output  1  one-cycle pulse at one-shot completion.
- periods  output  PERIOD_W  ticks since the last accepted start.

Behaviour:
- FSM states: IDLE, LOAD, RUN.
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - Latched start_val, end_val and mode, plus periods, go to 0.
  - All outputs are 0 during reset and after release until a start is accepted.
- IDLE:
  - en_o=0, ld_o=0, busy=0.
  - start=1 and stop=0 at an edge: latch start_val, end_val and mode; clear periods; go to LOAD.
- LOAD (exactly one cycle):
  - ld_o=1, d_o=latched start_val, en_o=0.
  - At the next edge the counter loads start_val and the FSM goes to RUN.
- RUN:
  - match = (q_in == latched end_val).
  - en_o = !match && !stop (combinational).
  - tick = match && !stop (combinational; one cycle because the state leaves RUN at the next edge).
  - done = tick && latched mode==0.
  - On an edge with match=1: periods increments, wrapping from 2^PERIOD_W-1 to 0. Auto-reload goes to LOAD; one-shot goes to IDLE.
- The controller never asserts ld_o and en_o in the same cycle, so counter ld/en priority is irrelevant.
- d_o holds the latched start_val in all states; it is 0 after reset.
- Period:
  - Span = (end_val - start_val) mod 2^n increments; the counter wraps from 2^n-1 to 0 naturally.
  - Auto-reload period = span + 2 cycles (1 LOAD + span+1 RUN).
  - end_val == start_val gives a period of 2 cycles.
- stop=1 in LOAD or RUN:
  - en_o and ld_o are forced to 0 that cycle, and tick/done are suppressed even if match=1.
  - Next state is IDLE; periods keeps its value.
- start while busy is ignored. start and stop together in IDLE: start is not accepted.
- start_val, end_val and mode changes while busy have no effect until the next accepted start.
- Latency:
  - ld_o rises in the cycle after the start-sampling edge.
  - First tick comes span+1 edges after that edge.
- The counter receives the same resetn, so both reset to q=0 together.

Test Plan:
- One-shot, n=4, start_val=3, end_val=7, start pulsed 1 cycle -> ld_o=1 for 1 cycle with d_o=3; q steps 3,4,5,6,7; tick=done=1 for exactly one cycle while q=7; busy falls next edge; q holds 7; periods=1.
- Auto-reload, start_val=3, end_val=7 -> tick every 6 cycles; q sequence 3..7,3..7; periods counts 1,2,3…; done never asserts.
- Wrap-around, auto-reload, start_val=14, end_val=1 -> q sequence 14,15,0,1; tick period 5 cycles. Equal case start_val=end_val=5 -> tick every 2 cycles, q stays 5.
- stop asserted in RUN on the cycle q==end_val -> no tick, no done, en_o=0, IDLE next edge, periods unchanged. start while busy, and start_val changed mid-run -> no effect on the current sequence.
- resetn pulled low mid-RUN (not clock-aligned) -> en_o, ld_o, busy, tick, done and periods go to 0 immediately; after release, IDLE until a new start is accepted.
